// File: rtl/router_pkg.sv
// Shared router definitions: FSM state encodings, address constants and
// small helpers used by router_fsm, router_synchronizer and the router top.
package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  localparam logic [1:0] ADDR_0       = 2'b00;
  localparam logic [1:0] ADDR_1       = 2'b01;
  localparam logic [1:0] ADDR_2       = 2'b10;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef struct packed {
    logic detect_addr;
    logic wr_en_reg;
    logic lfd_state;
    logic ld_state;
    logic laf_state;
    logic full_state;
    logic rst_int_reg;
    logic busy;
  } fsm_out_t;

  localparam fsm_out_t FSM_OUT_RESET = '{
    detect_addr: 1'b1,
    default:     1'b0
  };

  // Pick one of three per-FIFO flags by address; the invalid
  // address selects nothing.
  function automatic logic sel3(
    input logic [1:0] a,
    input logic       f0,
    input logic       f1,
    input logic       f2
  );
    logic r;
    r = 1'b0;
    case (a)
      ADDR_0:  r = f0;
      ADDR_1:  r = f1;
      ADDR_2:  r = f2;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Moore output decode for a state.
  function automatic fsm_out_t decode_state(input state_t s);
    fsm_out_t o;
    o = '0;
    case (s)
      DECODE_ADDRESS: begin
        o.detect_addr = 1'b1;
      end
      LOAD_FIRST_DATA: begin
        o.lfd_state = 1'b1;
        o.busy      = 1'b1;
      end
      LOAD_DATA: begin
        o.ld_state  = 1'b1;
        o.wr_en_reg = 1'b1;
      end
      FIFO_FULL_STATE: begin
        o.full_state = 1'b1;
        o.busy       = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        o.laf_state = 1'b1;
        o.wr_en_reg = 1'b1;
        o.busy      = 1'b1;
      end
      LOAD_PARITY: begin
        o.wr_en_reg = 1'b1;
        o.busy      = 1'b1;
      end
      CHECK_PARITY_ERROR: begin
        o.rst_int_reg = 1'b1;
        o.busy        = 1'b1;
      end
      WAIT_TILL_EMPTY: begin
        o.busy = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet-control FSM of the 1x3 router: header decode, payload load,
//   FIFO-full stall, parity check and busy back-pressure.
// Ports:
//   clk, rstn                    clock, async active-low reset
//   pkt_valid, d_in[1:0]         source byte valid and header address
//   empty_0..2, fifo_full        destination FIFO status
//   sft_rst_0..2                 per-FIFO soft resets
//   parity_done, low_pkt_valid   register-block status
//   detect_addr, wr_en_reg,
//   lfd_state, ld_state,
//   laf_state, full_state,
//   rst_int_reg, busy            registered Moore outputs
module router_fsm
  import router_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       pkt_valid,
  input  logic [1:0] d_in,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       fifo_full,
  input  logic       sft_rst_0,
  input  logic       sft_rst_1,
  input  logic       sft_rst_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_addr,
  output logic       wr_en_reg,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy
);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] addr_q;
  logic [1:0] addr_d;
  fsm_out_t   out_q;

  logic hdr_empty;
  logic empty_sel;
  logic sft_sel;

  // Header path uses the live address; later states use the latch.
  assign hdr_empty = sel3(d_in, empty_0, empty_1, empty_2);
  assign empty_sel = sel3(addr_q, empty_0, empty_1, empty_2);
  assign sft_sel   = sel3(addr_q, sft_rst_0, sft_rst_1, sft_rst_2);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid && d_in != ADDR_INVALID) begin
          addr_d  = d_in;
          state_d = hdr_empty ? LOAD_FIRST_DATA
                              : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (empty_sel)
          state_d = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: begin
        state_d = LOAD_DATA;
      end
      LOAD_DATA: begin
        if (fifo_full)
          state_d = FIFO_FULL_STATE;
        else if (!pkt_valid)
          state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full)
          state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)
          state_d = DECODE_ADDRESS;
        else if (low_pkt_valid)
          state_d = LOAD_PARITY;
        else
          state_d = LOAD_DATA;
      end
      LOAD_PARITY: begin
        state_d = CHECK_PARITY_ERROR;
      end
      CHECK_PARITY_ERROR: begin
        state_d = fifo_full ? FIFO_FULL_STATE
                            : DECODE_ADDRESS;
      end
      default: state_d = DECODE_ADDRESS;
    endcase
    // Soft reset of the selected FIFO aborts the packet.
    if (state_q != DECODE_ADDRESS && sft_sel)
      state_d = DECODE_ADDRESS;
  end

  // Outputs are registered from the next-state decode, so they
  // track the state register with no input-to-output path.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= ADDR_0;
      out_q   <= FSM_OUT_RESET;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      out_q   <= decode_state(state_d);
    end
  end

  assign detect_addr = out_q.detect_addr;
  assign wr_en_reg   = out_q.wr_en_reg;
  assign lfd_state   = out_q.lfd_state;
  assign ld_state    = out_q.ld_state;
  assign laf_state   = out_q.laf_state;
  assign full_state  = out_q.full_state;
  assign rst_int_reg = out_q.rst_int_reg;
  assign busy        = out_q.busy;

endmodule

// File: tb/tb_router_fsm.sv
// Directed testbench for router_fsm: each task drives one scenario
//   and compares the packed output vector against hand-built values.
module tb_router_fsm;

  logic       clk;
  logic       rstn;
  logic       pkt_valid;
  logic [1:0] d_in;
  logic       empty_0, empty_1, empty_2;
  logic       fifo_full;
  logic       sft_rst_0, sft_rst_1, sft_rst_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_addr, wr_en_reg, lfd_state, ld_state;
  logic       laf_state, full_state, rst_int_reg, busy;

  int vecs;
  int errs;

  // {detect, wr_en, lfd, ld, laf, full, rst_int, busy}
  localparam logic [7:0] O_DA  = 8'b1000_0000;
  localparam logic [7:0] O_LFD = 8'b0010_0001;
  localparam logic [7:0] O_LD  = 8'b0101_0000;
  localparam logic [7:0] O_FUL = 8'b0000_0101;
  localparam logic [7:0] O_LAF = 8'b0100_1001;
  localparam logic [7:0] O_LP  = 8'b0100_0001;
  localparam logic [7:0] O_CPE = 8'b0000_0011;
  localparam logic [7:0] O_WTE = 8'b0000_0001;

  logic [7:0] obs;
  assign obs = {detect_addr, wr_en_reg, lfd_state, ld_state,
                laf_state, full_state, rst_int_reg, busy};

  router_fsm dut (
    .clk           (clk),
    .rstn          (rstn),
    .pkt_valid     (pkt_valid),
    .d_in          (d_in),
    .empty_0       (empty_0),
    .empty_1       (empty_1),
    .empty_2       (empty_2),
    .fifo_full     (fifo_full),
    .sft_rst_0     (sft_rst_0),
    .sft_rst_1     (sft_rst_1),
    .sft_rst_2     (sft_rst_2),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .detect_addr   (detect_addr),
    .wr_en_reg     (wr_en_reg),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    pkt_valid = 0; d_in = 2'b00;
    empty_0 = 1; empty_1 = 1; empty_2 = 1;
    fifo_full = 0; parity_done = 0; low_pkt_valid = 0;
    sft_rst_0 = 0; sft_rst_1 = 0; sft_rst_2 = 0;
    #12;
    vecs++;
    if (obs !== O_DA) begin
      $display("FAIL reset: got %b want %b", obs, O_DA);
      errs++;
    end
    rstn = 1'b1;
    step();
    vecs++;
    if (obs !== O_DA) begin
      $display("FAIL idle: got %b want %b", obs, O_DA);
      errs++;
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp [7];
    exp = '{O_LFD, O_LD, O_LD, O_LD, O_LP, O_CPE, O_DA};
    pkt_valid = 1; d_in = 2'b01; empty_1 = 1;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) pkt_valid = 0;
      step();
      if (i == 0) d_in = 2'b00;
      vecs++;
      if (obs !== exp[i]) begin
        $display("FAIL basic[%0d]: got %b want %b",
                 i, obs, exp[i]);
        errs++;
      end
    end
  endtask

  task automatic test_busy_dest();
    pkt_valid = 1; d_in = 2'b10; empty_2 = 0;
    step();
    pkt_valid = 0; d_in = 2'b00;
    for (int i = 0; i < 6; i++) begin
      vecs++;
      if (obs !== O_WTE) begin
        $display("FAIL wait[%0d]: got %b want %b",
                 i, obs, O_WTE);
        errs++;
      end
      step();
    end
    empty_2 = 1;
    step();
    vecs++;
    if (obs !== O_LFD) begin
      $display("FAIL wait_release: got %b want %b", obs, O_LFD);
      errs++;
    end
    step(); step();
    vecs++;
    if (obs !== O_LP) begin
      $display("FAIL wait_parity: got %b want %b", obs, O_LP);
      errs++;
    end
    step(); step();
    vecs++;
    if (obs !== O_DA) begin
      $display("FAIL wait_end: got %b want %b", obs, O_DA);
      errs++;
    end
  endtask

  task automatic test_full();
    // Stall then low_pkt_valid path to parity.
    pkt_valid = 1; d_in = 2'b00; empty_0 = 1;
    step(); step();
    fifo_full = 1;
    step();
    vecs++;
    if (obs !== O_FUL) begin
      $display("FAIL full_enter: got %b want %b", obs, O_FUL);
      errs++;
    end
    step();
    vecs++;
    if (obs !== O_FUL) begin
      $display("FAIL full_hold: got %b want %b", obs, O_FUL);
      errs++;
    end
    fifo_full = 0;
    step();
    vecs++;
    if (obs !== O_LAF) begin
      $display("FAIL laf: got %b want %b", obs, O_LAF);
      errs++;
    end
    pkt_valid = 0; low_pkt_valid = 1;
    step();
    low_pkt_valid = 0;
    vecs++;
    if (obs !== O_LP) begin
      $display("FAIL laf_lowpv: got %b want %b", obs, O_LP);
      errs++;
    end
    step();
    // Full again during parity check returns to the stall.
    fifo_full = 1;
    step();
    vecs++;
    if (obs !== O_FUL) begin
      $display("FAIL cpe_full: got %b want %b", obs, O_FUL);
      errs++;
    end
    fifo_full = 0;
    step();
    vecs++;
    if (obs !== O_LAF) begin
      $display("FAIL laf2: got %b want %b", obs, O_LAF);
      errs++;
    end
    // Neither flag: back to payload load.
    step();
    vecs++;
    if (obs !== O_LD) begin
      $display("FAIL laf_ld: got %b want %b", obs, O_LD);
      errs++;
    end
    fifo_full = 1;
    step();
    fifo_full = 0;
    step();
    parity_done = 1; low_pkt_valid = 1;
    step();
    parity_done = 0; low_pkt_valid = 0;
    vecs++;
    if (obs !== O_DA) begin
      $display("FAIL laf_pdone: got %b want %b", obs, O_DA);
      errs++;
    end
  endtask

  task automatic test_soft_reset();
    pkt_valid = 1; d_in = 2'b01; empty_1 = 1;
    step(); step();
    sft_rst_0 = 1; sft_rst_2 = 1;
    step();
    sft_rst_0 = 0; sft_rst_2 = 0;
    vecs++;
    if (obs !== O_LD) begin
      $display("FAIL sft_other: got %b want %b", obs, O_LD);
      errs++;
    end
    pkt_valid = 0;
    sft_rst_1 = 1;
    step();
    sft_rst_1 = 0;
    vecs++;
    if (obs !== O_DA) begin
      $display("FAIL sft_sel: got %b want %b", obs, O_DA);
      errs++;
    end
    step();
    vecs++;
    if (obs !== O_DA) begin
      $display("FAIL sft_idle: got %b want %b", obs, O_DA);
      errs++;
    end
  endtask

  task automatic test_invalid();
    pkt_valid = 1; d_in = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      vecs++;
      if (obs !== O_DA) begin
        $display("FAIL invalid[%0d]: got %b want %b",
                 i, obs, O_DA);
        errs++;
      end
    end
    pkt_valid = 0; d_in = 2'b00;
  endtask

  task automatic test_async_reset();
    pkt_valid = 1; d_in = 2'b00; empty_0 = 1;
    step(); step();
    fifo_full = 1;
    step();
    fifo_full = 0;
    step();
    vecs++;
    if (obs !== O_LAF) begin
      $display("FAIL pre_rst: got %b want %b", obs, O_LAF);
      errs++;
    end
    #2 rstn = 0;
    #1;
    vecs++;
    if (obs !== O_DA) begin
      $display("FAIL async_rst: got %b want %b", obs, O_DA);
      errs++;
    end
    pkt_valid = 0;
    step();
    rstn = 1;
    step();
    vecs++;
    if (obs !== O_DA) begin
      $display("FAIL post_rst: got %b want %b", obs, O_DA);
      errs++;
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_basic();
    test_busy_dest();
    test_full();
    test_soft_reset();
    test_invalid();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
# router_fsm

Packet-control state machine of the 1x3 router. It sits directly upstream of `router_synchronizer` and drives its `detect_addr` and `wr_en_reg` inputs. It consumes the synchronizer's `fifo_full` and `sft_rst_*` outputs and the per-FIFO `empty_*` flags. It sequences every packet through header decode, payload load, FIFO-full stall and parity check, and supplies `busy` back-pressure to the source.

## Interface
- No parameters; widths are fixed by the router packet format.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `pkt_valid` in 1: source asserts for header and payload bytes, deasserts with the parity byte.
- `d_in` in 2: header address bits [1:0] of the current input byte; 00/01/10 select FIFO 0/1/2, 11 is invalid.
- `empty_0`, `empty_1`, `empty_2` in 1 each: destination FIFO empty flags.
- `fifo_full` in 1: full flag of the selected FIFO, from the synchronizer.
- `sft_rst_0`, `sft_rst_1`, `sft_rst_2` in 1 each: soft resets from the synchronizer.
- `parity_done` in 1: register block has written parity.
- `low_pkt_valid` in 1: register block saw `pkt_valid` fall while stalled.
- `detect_addr` out 1: header-decode cycle; goes to the synchronizer.
- `wr_en_reg` out 1: write enable to the synchronizer/register block.
- `lfd_state` out 1: the current byte is the header.
- `ld_state` out 1: payload load.
- `laf_state` out 1: load-after-full.
- `full_state` out 1: FIFO-full stall.
- `rst_int_reg` out 1: clear internal parity registers.
- `busy` out 1: source must hold its byte.

## Operation
States are DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY and CHECK_PARITY_ERROR.

**Address latch**
- A 2-bit `addr_q` captures `d_in` on the edge that leaves DECODE_ADDRESS with `pkt_valid=1` and `d_in!=11`.
- `empty_sel` is `empty_[addr_q]`; `sft_sel` is `sft_rst_[addr_q]`.

**Transitions**
- DECODE_ADDRESS:
  - `pkt_valid` and `d_in=n` (n<3) with `empty_n=1` → LOAD_FIRST_DATA.
  - `pkt_valid` and `d_in=n` with `empty_n=0` → WAIT_TILL_EMPTY.
  - Otherwise stay; `d_in=11` packets are ignored.
- WAIT_TILL_EMPTY: `empty_sel=1` → LOAD_FIRST_DATA, else stay.
- LOAD_FIRST_DATA → LOAD_DATA, unconditionally.
- LOAD_DATA: `fifo_full=1` → FIFO_FULL_STATE; else `pkt_valid=0` → LOAD_PARITY; else stay. `fifo_full` has priority.
- FIFO_FULL_STATE: `fifo_full=0` → LOAD_AFTER_FULL, else stay.
- LOAD_AFTER_FULL: `parity_done=1` → DECODE_ADDRESS; else `low_pkt_valid=1` → LOAD_PARITY; else → LOAD_DATA. `parity_done` has priority.
- LOAD_PARITY → CHECK_PARITY_ERROR, unconditionally.
- CHECK_PARITY_ERROR: `fifo_full=1` → FIFO_FULL_STATE, else → DECODE_ADDRESS.

**Soft reset**
- In any state other than DECODE_ADDRESS, `sft_sel=1` forces DECODE_ADDRESS on the next edge, overriding all other transitions.
- Soft resets of non-selected FIFOs are ignored.

**Outputs** are Moore decodes of the state register only:
- DECODE_ADDRESS: `detect_addr=1`, `busy=0`.
- LOAD_FIRST_DATA: `lfd_state=1`, `busy=1`.
- LOAD_DATA: `ld_state=1`, `wr_en_reg=1`, `busy=0`.
- FIFO_FULL_STATE: `full_state=1`, `busy=1`, `wr_en_reg=0`.
- LOAD_AFTER_FULL: `laf_state=1`, `wr_en_reg=1`, `busy=1`.
- LOAD_PARITY: `wr_en_reg=1`, `busy=1`.
- CHECK_PARITY_ERROR: `rst_int_reg=1`, `busy=1`.
- WAIT_TILL_EMPTY: `busy=1`.
- Every output not listed for a state is 0.

## Timing
- `rstn=0` immediately (asynchronously) forces state DECODE_ADDRESS and `addr_q=00`.
  - Output reset values: `detect_addr=1`; `busy`, `wr_en_reg`, `lfd_state`, `ld_state`, `laf_state`, `full_state` and `rst_int_reg` all 0.
- Reset mid-packet (any state) gives the same result; the packet is dropped.
- Header accepted at edge k:
  - `lfd_state=1` in cycle k+1.
  - `ld_state=1` and `wr_en_reg=1` from cycle k+2.
- Payload load:
  - One byte per cycle while in LOAD_DATA.
  - `fifo_full` rising in cycle j gives `busy=1` and `wr_en_reg=0` from cycle j+1.
- Packet end:
  - `pkt_valid` low in LOAD_DATA: LOAD_PARITY next cycle, CHECK_PARITY_ERROR the cycle after, then DECODE_ADDRESS.
  - Minimum packet turnaround is therefore 5 cycles from header to next decode.
- Inputs are sampled only at rising edges; outputs have no combinational input-to-output path.

## Structure
- Shared package `router_pkg`:
  - 3-bit state encodings for all eight states.
  - Address constants ADDR_0/1/2 and ADDR_INVALID=2'b11.
  - Also used by `router_synchronizer` and the router top.
- Single module: state register, `addr_q` register, next-state block and output decode. No sub-module.

## Test plan
- **Basic packet.** Reset, then `pkt_valid=1`, `d_in=01`, `empty_1=1`.
  - Required sequence: `lfd_state`, then `ld_state`/`wr_en_reg` for 3 payload cycles.
  - Then drop `pkt_valid`: LOAD_PARITY, then `rst_int_reg=1` for one cycle, then `detect_addr=1`.
- **Busy destination.** `d_in=10`, `empty_2=0`.
  - `busy=1`, `wr_en_reg=0` held for 6 cycles.
  - `empty_2=1` gives `lfd_state=1` on the next edge.
- **Full stall.** Assert `fifo_full` in LOAD_DATA.
  - `full_state=1`, `busy=1` until release.
  - Then `laf_state=1`; with `low_pkt_valid=1`, go to LOAD_PARITY.
  - Repeat with `parity_done=1`: go to DECODE_ADDRESS.
- **Soft reset.** Packet to address 01.
  - Pulse `sft_rst_0` in LOAD_DATA: ignored.
  - Pulse `sft_rst_1`: `detect_addr=1` next cycle.
- **Invalid address.** `d_in=11` with `pkt_valid=1` for 4 cycles: `detect_addr` stays 1, `busy=0`.
- **Async reset mid-packet.** Deassert `rstn` between edges in LOAD_AFTER_FULL: all outputs at reset values before the next edge.
